// File: rtl/gemm_tile_scheduler.sv
// Tile-loop sequencer for the 16x16 int8 systolic array: walks m/n/k tiles
// and handshakes with loader, array, accumulator and C writeback.
module gemm_tile_scheduler #(
    parameter int DIM_W = 8,
    parameter int CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [DIM_W-1:0] i_mTiles,
    input  logic [DIM_W-1:0] i_kTiles,
    input  logic [DIM_W-1:0] i_nTiles,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_fetchValid,
    input  logic             i_fetchReady,
    output logic [DIM_W-1:0] o_tileM,
    output logic [DIM_W-1:0] o_tileK,
    output logic [DIM_W-1:0] o_tileN,
    input  logic             i_tileLoaded,
    output logic             o_saValid,
    input  logic             i_saValid,
    output logic             o_accEn,
    output logic             o_accFirst,
    output logic             o_accLast,
    output logic             o_wbValid,
    input  logic             i_wbReady,
    output logic [CNT_W-1:0] o_tileCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_LD,
        S_ISSUE,
        S_COMPUTE,
        S_ACC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [DIM_W-1:0] D_ONE = 1;
    localparam logic [CNT_W-1:0] C_ONE = 1;

    state_t           state, state_n;
    logic [DIM_W-1:0] m_tiles, k_tiles, n_tiles;
    logic [DIM_W-1:0] m_tiles_n, k_tiles_n, n_tiles_n;
    logic [DIM_W-1:0] m_n, k_n, n_n;
    logic [CNT_W-1:0] cnt_n;
    logic             err_n;
    logic             dims_ok, k_last, n_last, m_last;

    logic busy_n, done_n, fetch_n, sa_n, acc_n, first_n, last_n, wb_n;

    assign dims_ok = (|i_mTiles) && (|i_kTiles) && (|i_nTiles);
    assign k_last  = (o_tileK == k_tiles - D_ONE);
    assign n_last  = (o_tileN == n_tiles - D_ONE);
    assign m_last  = (o_tileM == m_tiles - D_ONE);

    always_comb begin
        state_n   = state;
        m_tiles_n = m_tiles;
        k_tiles_n = k_tiles;
        n_tiles_n = n_tiles;
        m_n       = o_tileM;
        k_n       = o_tileK;
        n_n       = o_tileN;
        cnt_n     = o_tileCount;
        err_n     = o_err;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    if (dims_ok) begin
                        m_tiles_n = i_mTiles;
                        k_tiles_n = i_kTiles;
                        n_tiles_n = i_nTiles;
                        m_n       = '0;
                        k_n       = '0;
                        n_n       = '0;
                        cnt_n     = '0;
                        err_n     = 1'b0;
                        state_n   = S_FETCH;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (i_fetchReady) state_n = S_WAIT_LD;
            end
            S_WAIT_LD: begin
                if (i_tileLoaded) begin
                    cnt_n   = o_tileCount + C_ONE;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = S_COMPUTE;
            S_COMPUTE: begin
                if (i_saValid) state_n = S_ACC;
            end
            S_ACC: begin
                if (k_last) begin
                    state_n = S_WB;
                end else begin
                    k_n     = o_tileK + D_ONE;
                    state_n = S_FETCH;
                end
            end
            S_WB: begin
                if (i_wbReady) begin
                    if (m_last && n_last) begin
                        state_n = S_DONE;
                    end else begin
                        k_n     = '0;
                        state_n = S_FETCH;
                        if (n_last) begin
                            n_n = '0;
                            m_n = o_tileM + D_ONE;
                        end else begin
                            n_n = o_tileN + D_ONE;
                        end
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // abort freezes indices and count where they stand
        if (i_abort && state != S_IDLE && state != S_DONE) begin
            state_n = S_IDLE;
            m_n     = o_tileM;
            k_n     = o_tileK;
            n_n     = o_tileN;
            cnt_n   = o_tileCount;
        end
    end

    always_comb begin
        busy_n  = (state_n != S_IDLE);
        done_n  = (state_n == S_DONE);
        fetch_n = (state_n == S_FETCH);
        sa_n    = (state_n == S_ISSUE);
        acc_n   = (state_n == S_ACC);
        wb_n    = (state_n == S_WB);
        first_n = acc_n && (k_n == '0);
        last_n  = acc_n && (k_n == k_tiles_n - D_ONE);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state        <= S_IDLE;
            m_tiles      <= '0;
            k_tiles      <= '0;
            n_tiles      <= '0;
            o_tileM      <= '0;
            o_tileK      <= '0;
            o_tileN      <= '0;
            o_tileCount  <= '0;
            o_err        <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_fetchValid <= 1'b0;
            o_saValid    <= 1'b0;
            o_accEn      <= 1'b0;
            o_accFirst   <= 1'b0;
            o_accLast    <= 1'b0;
            o_wbValid    <= 1'b0;
        end else begin
            state        <= state_n;
            m_tiles      <= m_tiles_n;
            k_tiles      <= k_tiles_n;
            n_tiles      <= n_tiles_n;
            o_tileM      <= m_n;
            o_tileK      <= k_n;
            o_tileN      <= n_n;
            o_tileCount  <= cnt_n;
            o_err        <= err_n;
            o_busy       <= busy_n;
            o_done       <= done_n;
            o_fetchValid <= fetch_n;
            o_saValid    <= sa_n;
            o_accEn      <= acc_n;
            o_accFirst   <= first_n;
            o_accLast    <= last_n;
            o_wbValid    <= wb_n;
        end
    end

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Scoreboard bench for gemm_tile_scheduler: directed jobs push expected
// handshake events; a monitor pops and compares as the DUT produces them.
module tb_gemm_tile_scheduler;

    logic        i_clk = 1'b0;
    logic        i_arst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [7:0]  i_mTiles = '0;
    logic [7:0]  i_kTiles = '0;
    logic [7:0]  i_nTiles = '0;
    logic        i_fetchReady = 1'b0;
    logic        i_tileLoaded = 1'b0;
    logic        i_saValid = 1'b0;
    logic        i_wbReady = 1'b0;
    logic        o_busy, o_done, o_err, o_fetchValid, o_saValid;
    logic        o_accEn, o_accFirst, o_accLast, o_wbValid;
    logic [7:0]  o_tileM, o_tileK, o_tileN;
    logic [23:0] o_tileCount;

    gemm_tile_scheduler #(.DIM_W(8), .CNT_W(24)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n),
        .i_start(i_start), .i_abort(i_abort),
        .i_mTiles(i_mTiles), .i_kTiles(i_kTiles), .i_nTiles(i_nTiles),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_fetchValid(o_fetchValid), .i_fetchReady(i_fetchReady),
        .o_tileM(o_tileM), .o_tileK(o_tileK), .o_tileN(o_tileN),
        .i_tileLoaded(i_tileLoaded),
        .o_saValid(o_saValid), .i_saValid(i_saValid),
        .o_accEn(o_accEn), .o_accFirst(o_accFirst), .o_accLast(o_accLast),
        .o_wbValid(o_wbValid), .i_wbReady(i_wbReady),
        .o_tileCount(o_tileCount)
    );

    always #5 i_clk = ~i_clk;

    wire [56:0] outs = {o_busy, o_done, o_err, o_fetchValid, o_saValid,
                        o_accEn, o_accFirst, o_accLast, o_wbValid,
                        o_tileM, o_tileK, o_tileN, o_tileCount};

    typedef struct packed {
        logic [2:0]  kind;
        logic [7:0]  m;
        logic [7:0]  n;
        logic [7:0]  k;
        logic [23:0] a;
    } ev_t;

    localparam int EV_F = 1, EV_S = 2, EV_A = 3, EV_W = 4, EV_D = 5;

    ev_t exp_q[$];
    int  ncmp = 0;
    int  nfail = 0;

    function automatic ev_t mk(input int kd, input logic [7:0] m,
                               input logic [7:0] n, input logic [7:0] k,
                               input logic [23:0] a);
        ev_t e;
        e.kind = kd[2:0];
        e.m = m;
        e.n = n;
        e.k = k;
        e.a = a;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        ncmp++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic got_ev(input ev_t g);
        ev_t e;
        ncmp++;
        if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL event: got kind=%0d m=%0d n=%0d k=%0d a=%0d want none",
                     g.kind, g.m, g.n, g.k, g.a);
        end else begin
            e = exp_q.pop_front();
            if (e !== g) begin
                nfail++;
                $display("FAIL event: got kind=%0d m=%0d n=%0d k=%0d a=%0d want kind=%0d m=%0d n=%0d k=%0d a=%0d",
                         g.kind, g.m, g.n, g.k, g.a, e.kind, e.m, e.n, e.k, e.a);
            end
        end
    endtask

    // monitor: sample mid-cycle, after the driver has set this cycle's inputs
    always @(negedge i_clk) begin
        #1;
        if (i_arst_n) begin
            ncmp++;
            if (!o_accEn && (o_accFirst || o_accLast)) begin
                nfail++;
                $display("FAIL acc_qual: got first=%0b last=%0b want 0 0",
                         o_accFirst, o_accLast);
            end
            if (o_fetchValid && i_fetchReady)
                got_ev(mk(EV_F, o_tileM, o_tileN, o_tileK, 24'd0));
            if (o_saValid)
                got_ev(mk(EV_S, o_tileM, o_tileN, o_tileK, o_tileCount));
            if (o_accEn)
                got_ev(mk(EV_A, o_tileM, o_tileN, o_tileK,
                          {22'd0, o_accFirst, o_accLast}));
            if (o_wbValid && i_wbReady)
                got_ev(mk(EV_W, o_tileM, o_tileN, 8'd0, 24'd0));
            if (o_done)
                got_ev(mk(EV_D, 8'd0, 8'd0, 8'd0, {23'd0, o_err}));
        end
    end

    // expected event stream: m outer, n middle, k inner
    task automatic gen(input int mt, input int kt, input int nt, input int lim);
        int c;
        c = 0;
        for (int m = 0; m < mt; m++) begin
            for (int n = 0; n < nt; n++) begin
                for (int k = 0; k < kt; k++) begin
                    exp_q.push_back(mk(EV_F, m[7:0], n[7:0], k[7:0], 24'd0));
                    c++;
                    exp_q.push_back(mk(EV_S, m[7:0], n[7:0], k[7:0], c[23:0]));
                    if (lim != 0 && c == lim) return;
                    exp_q.push_back(mk(EV_A, m[7:0], n[7:0], k[7:0],
                                       {22'd0, k == 0, k == kt - 1}));
                end
                exp_q.push_back(mk(EV_W, m[7:0], n[7:0], 8'd0, 24'd0));
            end
        end
        exp_q.push_back(mk(EV_D, 8'd0, 8'd0, 8'd0, 24'd0));
    endtask

    task automatic clr_in();
        i_start = 1'b0;
        i_abort = 1'b0;
        i_fetchReady = 1'b0;
        i_tileLoaded = 1'b0;
        i_saValid = 1'b0;
        i_wbReady = 1'b0;
    endtask

    task automatic run_job(input int mt, input int kt, input int nt,
                           input int fst, input int wst, input int lat,
                           input int ab, input int rw, input int sab);
        int wf, ww, sw, nsa;
        bit ld, ap, fin;
        logic [7:0] sm, sn, sk;
        wf = 0; ww = 0; sw = 0; nsa = 0;
        ld = 0; ap = 0; fin = 0;
        sm = '0; sn = '0; sk = '0;
        i_mTiles = mt[7:0];
        i_kTiles = kt[7:0];
        i_nTiles = nt[7:0];
        i_start = 1'b1;
        i_abort = sab[0];
        @(negedge i_clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (ap) begin
                clr_in();
                i_abort = 1'b1;
                @(negedge i_clk);
                i_abort = 1'b0;
                chk("abort_idle", {o_busy, o_fetchValid, o_saValid, o_accEn,
                                   o_wbValid, o_done}, 64'd0);
                chk("abort_count", o_tileCount, ab);
                fin = 1;
            end else if (o_done) begin
                fin = 1;
            end else if (rw != 0 && o_wbValid && ww == 3) begin
                clr_in();
                i_arst_n = 1'b0;
                #1;
                chk("async_rst", outs, 64'd0);
                #3;
                i_arst_n = 1'b1;
                fin = 1;
            end else begin
                i_tileLoaded = ld;
                ld = 0;
                i_saValid = 1'b0;
                if (sw > 0) begin
                    sw--;
                    if (sw == 0) i_saValid = 1'b1;
                end
                if (o_saValid) begin
                    nsa++;
                    sw = lat;
                    if (nsa == ab) ap = 1;
                end
                i_fetchReady = 1'b0;
                if (o_fetchValid) begin
                    if (wf > 0) chk("fetch_hold", {o_tileM, o_tileN, o_tileK},
                                    {sm, sn, sk});
                    else begin
                        sm = o_tileM; sn = o_tileN; sk = o_tileK;
                    end
                    if (wf < fst) wf++;
                    else begin
                        i_fetchReady = 1'b1;
                        wf = 0;
                        ld = 1;
                    end
                end
                i_wbReady = 1'b0;
                if (o_wbValid) begin
                    if (ww > 0) chk("wb_hold", {o_tileM, o_tileN}, {sm, sn});
                    else begin
                        sm = o_tileM; sn = o_tileN;
                    end
                    if (ww < wst) ww++;
                    else begin
                        i_wbReady = 1'b1;
                        ww = 0;
                    end
                end
                @(negedge i_clk);
            end
        end
        if (!fin) begin
            ncmp++;
            nfail++;
            $display("FAIL timeout: got no completion want done within budget");
        end
        clr_in();
    endtask

    task automatic post(input int cnt_want);
        @(negedge i_clk);
        #2;
        chk("queue_empty", exp_q.size(), 64'd0);
        chk("idle_busy", o_busy, 64'd0);
        if (cnt_want >= 0) chk("tile_count", o_tileCount, cnt_want);
        exp_q.delete();
    endtask

    initial begin
        #2;
        chk("reset", outs, 64'd0);
        @(negedge i_clk);
        i_arst_n = 1'b1;
        @(negedge i_clk);

        gen(1, 1, 1, 0);
        run_job(1, 1, 1, 0, 0, 1, 0, 0, 0);
        post(1);

        gen(2, 3, 2, 0);
        run_job(2, 3, 2, 0, 0, 2, 0, 0, 0);
        post(12);

        gen(1, 2, 1, 0);
        run_job(1, 2, 1, 5, 7, 1, 0, 0, 0);
        post(2);

        exp_q.push_back(mk(EV_D, 8'd0, 8'd0, 8'd0, 24'd1));
        run_job(2, 0, 2, 0, 0, 1, 0, 0, 0);
        post(-1);
        chk("err_sticky", o_err, 64'd1);

        gen(1, 1, 1, 0);
        run_job(1, 1, 1, 0, 0, 1, 0, 0, 0);
        post(1);
        chk("err_cleared", o_err, 64'd0);

        gen(2, 2, 2, 3);
        run_job(2, 2, 2, 0, 0, 2, 3, 0, 0);
        post(3);

        gen(2, 1, 2, 0);
        run_job(2, 1, 2, 0, 0, 1, 0, 0, 1);
        post(4);

        exp_q.push_back(mk(EV_F, 8'd0, 8'd0, 8'd0, 24'd0));
        exp_q.push_back(mk(EV_S, 8'd0, 8'd0, 8'd0, 24'd1));
        exp_q.push_back(mk(EV_A, 8'd0, 8'd0, 8'd0, 24'd3));
        run_job(1, 1, 1, 0, 10, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_saValid = 1'b1;
            i_tileLoaded = 1'b1;
            i_fetchReady = 1'b1;
            i_wbReady = 1'b1;
            @(negedge i_clk);
            clr_in();
            chk("stray_idle", outs, 64'd0);
        end
        post(0);

        gen(1, 1, 1, 0);
        run_job(1, 1, 1, 0, 0, 1, 0, 0, 0);
        post(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
